rr_stream_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready stream, the shift-register plus FIFO datapath, between N_REQ upstream requesters. It selects one requester per transfer, forwards that beat through a single registered output stage, and tags each beat with its source index. It sits directly in front of the datapath's up_data/up_valid/up_ready port.

---
 rtl/rr_arb_pkg.sv | 14 +
 rtl/rr_prio_pick.sv | 30 +++
 rtl/rr_stream_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rr_stream_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the rr_stream_arbiter slice.
package rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Wrap-around increment of an index that lives in [0, n-1].
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: combinational rotating-priority picker. Returns the first
// requester at or above ptr (wrapping modulo N_REQ) that asserts req.
module rr_prio_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int S_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [S_WIDTH-1:0] ptr,
    output logic [S_WIDTH-1:0] g,
    output logic               gv
);

    // Walk the ring once starting at ptr; the first asserted request wins.
    always_comb begin
        int idx;
        g   = '0;
        gv  = 1'b0;
        idx = 32'(ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (!gv && req[idx]) begin
                gv = 1'b1;
                g  = S_WIDTH'(idx);
            end
            idx = next_idx(idx, N_REQ);
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin arbiter sharing one valid/ready stream between
// N_REQ requesters, with a single registered output stage tagged by source.
// Optional burst lock (owner keeps the grant for BURST_LEN beats) is compiled
// in by defining RR_ARB_BURST_LOCK_EN; the default build re-arbitrates per beat.
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter int D_WIDTH   = 6,
    parameter int N_REQ     = 4,
    parameter int BURST_LEN = 4,
    parameter int S_WIDTH   = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ*D_WIDTH-1:0]   up_data,
    input  logic [N_REQ-1:0]           up_valid,
    output logic [N_REQ-1:0]           up_ready,
    output logic [D_WIDTH-1:0]         down_data,
    output logic [S_WIDTH-1:0]         down_src,
    output logic                       down_valid,
    input  logic                       down_ready
);

    logic [S_WIDTH-1:0] ptr_q, ptr_d;
    logic [S_WIDTH-1:0] pick_g;
    logic               pick_gv;
    logic [S_WIDTH-1:0] gnt;
    logic               gnt_v;
    logic               accept;
    logic               xfer;

    logic [D_WIDTH-1:0] data_q, data_d;
    logic [S_WIDTH-1:0] src_q, src_d;
    logic               vld_q, vld_d;

    if (N_REQ < 2 || N_REQ > 16 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_param_check
        $error("rr_stream_arbiter: N_REQ must be 2..16 and BURST_LEN 1..16");
    end

    rr_prio_pick #(
        .N_REQ   (N_REQ),
        .S_WIDTH (S_WIDTH)
    ) u_pick (
        .req (up_valid),
        .ptr (ptr_q),
        .g   (pick_g),
        .gv  (pick_gv)
    );

    // The output stage can take a new beat when empty or being drained.
    assign accept = !vld_q || down_ready;

`ifdef RR_ARB_BURST_LOCK_EN
    localparam int C_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_e         state_q, state_d;
    logic [S_WIDTH-1:0] own_q, own_d;
    logic [C_WIDTH-1:0] cnt_q, cnt_d;

    // Burst FSM: pick grant source, and advance owner, beat count and pointer.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt     = pick_g;
        gnt_v   = pick_gv;
        if (state_q == ARB_LOCKED) begin
            gnt   = own_q;
            gnt_v = up_valid[own_q];
            if (!up_valid[own_q]) begin
                // Owner went quiet: give up the lock, costing one bubble cycle.
                state_d = ARB_IDLE;
                cnt_d   = '0;
                ptr_d   = S_WIDTH'(next_idx(32'(own_q), N_REQ));
            end else if (accept) begin
                if (cnt_q == C_WIDTH'(BURST_LEN - 1)) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                    ptr_d   = S_WIDTH'(next_idx(32'(own_q), N_REQ));
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else if (pick_gv && accept) begin
            if (BURST_LEN > 1) begin
                // First beat of a burst: lock onto the winner, pointer stays put.
                state_d = ARB_LOCKED;
                own_d   = pick_g;
                cnt_d   = C_WIDTH'(1);
            end else begin
                ptr_d = S_WIDTH'(next_idx(32'(pick_g), N_REQ));
            end
        end
    end

    // Burst FSM state, owner and beat counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            own_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    // Plain round-robin: every beat re-arbitrates and the pointer skips past the winner.
    always_comb begin
        gnt   = pick_g;
        gnt_v = pick_gv;
        ptr_d = ptr_q;
        if (pick_gv && accept) begin
            ptr_d = S_WIDTH'(next_idx(32'(pick_g), N_REQ));
        end
    end
`endif

    assign xfer = gnt_v && accept;

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // One-hot ready to the granted requester only; nothing while in reset.
    always_comb begin
        up_ready = '0;
        if (rst && xfer) begin
            up_ready[gnt] = 1'b1;
        end
    end

    // Output stage next state: load on transfer, otherwise hold or drain.
    always_comb begin
        data_d = data_q;
        src_d  = src_q;
        vld_d  = vld_q;
        if (xfer) begin
            data_d = up_data[32'(gnt) * D_WIDTH +: D_WIDTH];
            src_d  = gnt;
            vld_d  = 1'b1;
        end else if (down_ready) begin
            vld_d = 1'b0;
        end
    end

    // Output stage register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            src_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            src_q  <= src_d;
            vld_q  <= vld_d;
        end
    end

    assign down_data  = data_q;
    assign down_src   = src_q;
    assign down_valid = vld_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: scoreboard bench for rr_stream_arbiter (default 4x6-bit).
module tb_rr_stream_arbiter;

    localparam int DW = 6;
    localparam int NR = 4;
    localparam int BL = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*DW-1:0]  up_data = '0;
    logic [NR-1:0]     up_valid = '0;
    logic [NR-1:0]     up_ready;
    logic [DW-1:0]     down_data;
    logic [SW-1:0]     down_src;
    logic              down_valid;
    logic              down_ready = 1'b0;

    rr_stream_arbiter #(
        .D_WIDTH   (DW),
        .N_REQ     (NR),
        .BURST_LEN (BL),
        .S_WIDTH   (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_src   (down_src),
        .down_valid (down_valid),
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state and scoreboard of beats expected on down_*.
    int                 m_ptr  = 0;
    int                 m_own  = 0;
    int                 m_cnt  = 0;
    bit                 m_lock = 1'b0;
    bit                 m_dv   = 1'b0;
    logic [SW+DW-1:0]   sbq[$];
    int                 src_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check DUT against the model at the negedge, then advance.
    task automatic step();
        int          g;
        bit          acc;
        bit          xf;
        logic [NR-1:0] exp_rdy;
        logic [SW+DW-1:0] e;
        @(negedge clk);
        acc = !m_dv || down_ready;
        g   = -1;
        if (m_lock) begin
            if (up_valid[m_own]) g = m_own;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (g < 0 && up_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        xf = (g >= 0) && acc;
        if (xf) exp_rdy[g] = 1'b1;
        chk("up_ready", 32'(up_ready), 32'(exp_rdy));
        chk("down_valid", 32'(down_valid), 32'(m_dv));
        if (down_valid) begin
            if (sbq.size() == 0) begin
                chk("sb_occupancy", 32'(down_valid), 32'd0);
            end else begin
                e = sbq[0];
                chk("down_data", 32'(down_data), 32'(e[DW-1:0]));
                chk("down_src", 32'(down_src), 32'(e[DW +: SW]));
                if (down_ready) begin
                    void'(sbq.pop_front());
                    src_log.push_back(int'(down_src));
                end
            end
        end
        if (xf) sbq.push_back({SW'(g), up_data[g*DW +: DW]});
        m_dv = xf ? 1'b1 : (down_ready ? 1'b0 : m_dv);
`ifdef RR_ARB_BURST_LOCK_EN
        if (m_lock) begin
            if (!up_valid[m_own]) begin
                m_lock = 1'b0;
                m_cnt  = 0;
                m_ptr  = (m_own + 1) % NR;
            end else if (acc) begin
                if (m_cnt == BL - 1) begin
                    m_lock = 1'b0;
                    m_cnt  = 0;
                    m_ptr  = (m_own + 1) % NR;
                end else begin
                    m_cnt++;
                end
            end
        end else if (xf) begin
            if (BL > 1) begin
                m_lock = 1'b1;
                m_own  = g;
                m_cnt  = 1;
            end else begin
                m_ptr = (g + 1) % NR;
            end
        end
`else
        if (xf) m_ptr = (g + 1) % NR;
`endif
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_reset(input string tag);
        #3;
        rst = 1'b0;
        #1;
        chk({tag, "_down_valid"}, 32'(down_valid), 32'd0);
        chk({tag, "_up_ready"}, 32'(up_ready), 32'd0);
        sbq.delete();
        m_ptr  = 0;
        m_own  = 0;
        m_cnt  = 0;
        m_lock = 1'b0;
        m_dv   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int exp_seq[6];
        logic [NR-1:0] exp_reload;
        int exp_src_after;

        // Reset state, with every requester asserting valid to show ready is forced low.
        up_valid = '1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_down_valid", 32'(down_valid), 32'd0);
        chk("rst_down_data", 32'(down_data), 32'd0);
        chk("rst_down_src", 32'(down_src), 32'd0);
        chk("rst_up_ready", 32'(up_ready), 32'd0);
        up_valid = '0;
        rst = 1'b1;

        // All four valid, down_ready held high: check the grant order.
        up_data    = {6'h33, 6'h22, 6'h11, 6'h05};
        up_valid   = 4'b1111;
        down_ready = 1'b1;
        src_log.delete();
        for (int i = 0; i < 8; i++) step();
`ifdef RR_ARB_BURST_LOCK_EN
        exp_seq = '{0, 0, 0, 0, 1, 1};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1};
`endif
        chk("seq_len_ok", 32'(src_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("seq_src", (i < src_log.size()) ? 32'(src_log[i]) : 32'd99, 32'(exp_seq[i]));
        end

        // Backpressure: beat held for three cycles with no ready upstream.
        pulse_reset("rst_bp");
        down_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("hold_src", 32'(down_src), 32'd0);
            chk("hold_data", 32'(down_data), 32'h05);
            chk("hold_rdy", 32'(up_ready), 32'd0);
            step();
        end
        down_ready = 1'b1;
        #1;
`ifdef RR_ARB_BURST_LOCK_EN
        exp_reload    = 4'b0001;
        exp_src_after = 0;
`else
        exp_reload    = 4'b0010;
        exp_src_after = 1;
`endif
        chk("reload_rdy", 32'(up_ready), 32'(exp_reload));
        step();
        chk("reload_valid", 32'(down_valid), 32'd1);
        chk("reload_src", 32'(down_src), 32'(exp_src_after));

        // Single requester 2 streaming two beats back to back.
        pulse_reset("rst_single");
        up_valid = 4'b0100;
        up_data  = {6'h00, 6'h15, 6'h00, 6'h00};
        #1;
        chk("single_rdy0", 32'(up_ready), 32'b0100);
        step();
        up_data = {6'h00, 6'h2A, 6'h00, 6'h00};
        #1;
        chk("single_rdy1", 32'(up_ready), 32'b0100);
        chk("single_data0", 32'(down_data), 32'h15);
        chk("single_src0", 32'(down_src), 32'd2);
`ifndef RR_ARB_BURST_LOCK_EN
        chk("single_ptr0", 32'(dut.ptr_q), 32'd3);
`endif
        step();
        up_valid = 4'b0000;
        chk("single_data1", 32'(down_data), 32'h2A);
        chk("single_src1", 32'(down_src), 32'd2);
`ifndef RR_ARB_BURST_LOCK_EN
        chk("single_ptr1", 32'(dut.ptr_q), 32'd3);
`endif
        step();

`ifdef RR_ARB_BURST_LOCK_EN
        // Owner 1 drops valid after two beats: one bubble, then requester 2.
        pulse_reset("rst_drop");
        up_data  = {6'h04, 6'h03, 6'h02, 6'h01};
        up_valid = 4'b0110;
        step();
        step();
        up_valid = 4'b0100;
        #1;
        chk("drop_bubble_rdy", 32'(up_ready), 32'd0);
        step();
        chk("drop_rdy2", 32'(up_ready), 32'b0100);
        chk("drop_ptr", 32'(dut.ptr_q), 32'd2);
        step();
        chk("drop_src", 32'(down_src), 32'd2);
        up_valid = 4'b0000;
        step();
        step();
`endif

        // Reset in the middle of traffic, then restart from requester 0.
        up_data  = {6'h3C, 6'h2B, 6'h1A, 6'h09};
        up_valid = 4'b1111;
        step();
        step();
        pulse_reset("rst_mid");
        up_valid = 4'b1001;
        #1;
        chk("restart_rdy", 32'(up_ready), 32'b0001);
        step();
        chk("restart_src", 32'(down_src), 32'd0);
        chk("restart_data", 32'(down_data), 32'h09);

        // Random traffic checked against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            up_valid   = NR'($urandom_range(0, 15));
            up_data    = (NR*DW)'($urandom);
            down_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain whatever is left.
        up_valid   = '0;
        down_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        chk("drain_valid", 32'(down_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
